// File: rtl/hand_reader.sv
// Collects a hand of NUM_CARDS distinct cards (0..51), rejecting duplicates and
// out-of-range indices, then classifies the hand one cycle after the last card.
module hand_reader #(
    parameter int unsigned NUM_CARDS = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       card_valid,
    input  logic [5:0] card,
    output logic       card_ready,
    output logic       dup_err,
    output logic       range_err,
    output logic [2:0] count,
    output logic       busy,
    output logic       done,
    output logic [3:0] hand_class,
    output logic [3:0] high_rank
);

    typedef enum logic [1:0] {StIdle, StCollect, StEval, StDone} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [51:0] r_mask;
    logic [2:0]  r_rank_cnt [0:12];
    logic [2:0]  r_suit_cnt [0:3];
    logic [2:0]  r_count;
    logic        r_dup_err;
    logic        r_range_err;
    logic [3:0]  r_class;
    logic [3:0]  r_high;

    logic [63:0] w_mask_ext;
    logic        w_hs;
    logic        w_range;
    logic        w_held;
    logic        w_accept;
    logic        w_last;
    logic [3:0]  w_rank;
    logic [1:0]  w_suit;

    // Five consecutive ranks, including the ace-low wheel.
    function automatic logic f_straight(input logic [12:0] v);
        logic hit;
        hit = v[12] & v[0] & v[1] & v[2] & v[3];
        for (int lo = 0; lo <= 8; lo++) begin
            if (&v[lo +: 5]) hit = 1'b1;
        end
        return hit;
    endfunction

    assign w_mask_ext = {12'b0, r_mask};
    assign w_hs       = card_valid && card_ready && !start;
    assign w_range    = (card >= 6'd52);
    assign w_held     = w_mask_ext[card];
    assign w_accept   = w_hs && !w_range && !w_held;
    assign w_last     = w_accept && (r_count == 3'(NUM_CARDS - 1));
    assign w_rank     = 4'(card % 6'd13);
    assign w_suit     = 2'(card / 6'd13);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = StCollect;
        end else begin
            unique case (r_state)
                StIdle:    w_state_next = StIdle;
                StCollect: if (w_last) w_state_next = StEval;
                StEval:    w_state_next = StDone;
                StDone:    w_state_next = StDone;
                default:   w_state_next = StIdle;
            endcase
        end
    end

    // Hand evaluation from the registered mask and counters.
    logic [12:0] w_or;
    logic        w_sf;
    logic        w_straight;
    logic        w_flush;
    logic        w_quads;
    logic [3:0]  w_n2;
    logic [3:0]  w_n3;
    logic [3:0]  w_class;
    logic [3:0]  w_high;

    always_comb begin
        w_or       = '0;
        w_sf       = 1'b0;
        w_flush    = 1'b0;
        w_quads    = 1'b0;
        w_n2       = '0;
        w_n3       = '0;
        w_high     = '0;
        for (int s = 0; s < 4; s++) begin
            w_or = w_or | r_mask[s*13 +: 13];
            if (f_straight(r_mask[s*13 +: 13])) w_sf = 1'b1;
            if (r_suit_cnt[s] >= 3'd5) w_flush = 1'b1;
        end
        w_straight = f_straight(w_or);
        for (int r = 0; r < 13; r++) begin
            if (r_rank_cnt[r] >= 3'd2) w_n2 = w_n2 + 4'd1;
            if (r_rank_cnt[r] >= 3'd3) w_n3 = w_n3 + 4'd1;
            if (r_rank_cnt[r] == 3'd4) w_quads = 1'b1;
            if (r_rank_cnt[r] != 3'd0) w_high = 4'(r);
        end
        // A trips rank also counts toward w_n2, so full house needs a second pair-or-better.
        if (w_sf)                               w_class = 4'd8;
        else if (w_quads)                       w_class = 4'd7;
        else if (w_n3 >= 4'd1 && w_n2 >= 4'd2)  w_class = 4'd6;
        else if (w_flush)                       w_class = 4'd5;
        else if (w_straight)                    w_class = 4'd4;
        else if (w_n3 >= 4'd1)                  w_class = 4'd3;
        else if (w_n2 >= 4'd2)                  w_class = 4'd2;
        else if (w_n2 >= 4'd1)                  w_class = 4'd1;
        else                                    w_class = 4'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask      <= '0;
            r_count     <= '0;
            r_dup_err   <= 1'b0;
            r_range_err <= 1'b0;
            r_class     <= '0;
            r_high      <= '0;
            for (int r = 0; r < 13; r++) r_rank_cnt[r] <= '0;
            for (int s = 0; s < 4; s++) r_suit_cnt[s] <= '0;
        end else begin
            r_dup_err   <= 1'b0;
            r_range_err <= 1'b0;
            if (start) begin
                r_mask  <= '0;
                r_count <= '0;
                r_class <= '0;
                r_high  <= '0;
                for (int r = 0; r < 13; r++) r_rank_cnt[r] <= '0;
                for (int s = 0; s < 4; s++) r_suit_cnt[s] <= '0;
            end else begin
                if (w_hs) begin
                    if (w_range) begin
                        r_range_err <= 1'b1;
                    end else if (w_held) begin
                        r_dup_err <= 1'b1;
                    end
                end
                if (w_accept) begin
                    r_mask[card]       <= 1'b1;
                    r_rank_cnt[w_rank] <= r_rank_cnt[w_rank] + 3'd1;
                    r_suit_cnt[w_suit] <= r_suit_cnt[w_suit] + 3'd1;
                    r_count            <= r_count + 3'd1;
                end
                if (r_state == StEval) begin
                    r_class <= w_class;
                    r_high  <= w_high;
                end
            end
        end
    end

    assign card_ready = (r_state == StCollect);
    assign busy       = (r_state == StCollect) || (r_state == StEval);
    assign done       = (r_state == StDone);
    assign dup_err    = r_dup_err;
    assign range_err  = r_range_err;
    assign count      = r_count;
    assign hand_class = r_class;
    assign high_rank  = r_high;

endmodule

// File: tb/tb_hand_reader.sv
// Bench for hand_reader: directed hand table, error/reset/start corner cases, and
// random hands with injected duplicates and out-of-range cards against a list-based model.
module tb_hand_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       card_valid = 1'b0;
    logic [5:0] card = '0;
    logic       card_ready;
    logic       dup_err;
    logic       range_err;
    logic [2:0] count;
    logic       busy;
    logic       done;
    logic [3:0] hand_class;
    logic [3:0] high_rank;

    hand_reader #(.NUM_CARDS(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .card_valid (card_valid),
        .card       (card),
        .card_ready (card_ready),
        .dup_err    (dup_err),
        .range_err  (range_err),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .hand_class (hand_class),
        .high_rank  (high_rank)
    );

    always #5 clk = ~clk;

    typedef logic [6:0][5:0] hand_t;
    typedef struct packed {
        hand_t      c;
        logic [3:0] cls;
        logic [3:0] hi;
    } vec_t;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        card_valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic offer(input logic [5:0] c);
        card_valid = 1'b1;
        card = c;
        tick();
        card_valid = 1'b0;
    endtask

    function automatic hand_t mk(input int a, b, c, d, e, f, g);
        hand_t h;
        h[0] = 6'(a); h[1] = 6'(b); h[2] = 6'(c); h[3] = 6'(d);
        h[4] = 6'(e); h[5] = 6'(f); h[6] = 6'(g);
        return h;
    endfunction

    // Reference: classify directly from the list of seven cards.
    function automatic void ref_eval(input hand_t cs, output int cls, output int hi);
        int rc[13];
        int sc[4];
        bit pres[4][13];
        bit any[13];
        int n2, n3;
        bit quad, fl, st, sf, ok_a;
        bit ok_s[4];
        n2 = 0; n3 = 0; quad = 0; fl = 0; st = 0; sf = 0; hi = 0;
        for (int r = 0; r < 13; r++) begin
            rc[r] = 0; any[r] = 0;
            for (int s = 0; s < 4; s++) pres[s][r] = 0;
        end
        for (int s = 0; s < 4; s++) sc[s] = 0;
        for (int i = 0; i < 7; i++) begin
            int r, s;
            r = int'(cs[i]) % 13;
            s = int'(cs[i]) / 13;
            rc[r]++; sc[s]++; pres[s][r] = 1; any[r] = 1;
        end
        for (int r = 0; r < 13; r++) begin
            if (rc[r] > 0) hi = r;
            if (rc[r] >= 2) n2++;
            if (rc[r] >= 3) n3++;
            if (rc[r] == 4) quad = 1;
        end
        for (int s = 0; s < 4; s++) if (sc[s] >= 5) fl = 1;
        for (int top = 3; top <= 12; top++) begin
            ok_a = 1;
            for (int s = 0; s < 4; s++) ok_s[s] = 1;
            for (int k = 0; k < 5; k++) begin
                int rr;
                rr = top - k;
                if (rr < 0) rr += 13;
                if (!any[rr]) ok_a = 0;
                for (int s = 0; s < 4; s++) if (!pres[s][rr]) ok_s[s] = 0;
            end
            if (ok_a) st = 1;
            for (int s = 0; s < 4; s++) if (ok_s[s]) sf = 1;
        end
        if (sf) cls = 8;
        else if (quad) cls = 7;
        else if (n3 >= 1 && n2 >= 2) cls = 6;
        else if (fl) cls = 5;
        else if (st) cls = 4;
        else if (n3 >= 1) cls = 3;
        else if (n2 >= 2) cls = 2;
        else if (n2 >= 1) cls = 1;
        else cls = 0;
    endfunction

    // Called right after the edge accepting the last card.
    task automatic check_result(input int ecls, input int ehi);
        chk("eval_done_low", int'(done), 0);
        chk("eval_busy", int'(busy), 1);
        chk("eval_ready_low", int'(card_ready), 0);
        tick();
        chk("done_high", int'(done), 1);
        chk("done_busy_low", int'(busy), 0);
        chk("hand_class", int'(hand_class), ecls);
        chk("high_rank", int'(high_rank), ehi);
    endtask

    task automatic run_hand(input hand_t h, input int ecls, input int ehi);
        do_start();
        chk("start_count", int'(count), 0);
        chk("start_ready", int'(card_ready), 1);
        chk("start_busy", int'(busy), 1);
        chk("start_done", int'(done), 0);
        for (int i = 0; i < 7; i++) begin
            offer(h[i]);
            chk("accept_err", int'(dup_err | range_err), 0);
            if (i < 6) chk("accept_count", int'(count), i + 1);
        end
        check_result(ecls, ehi);
    endtask

    task automatic random_hand();
        bit used[52];
        hand_t hv;
        int c, ecls, ehi;
        for (int i = 0; i < 52; i++) used[i] = 0;
        for (int i = 0; i < 7; i++) begin
            do c = int'($urandom_range(0, 51)); while (used[c]);
            used[c] = 1;
            hv[i] = 6'(c);
        end
        do_start();
        for (int i = 0; i < 7; i++) begin
            case ($urandom_range(0, 5))
                0: if (i > 0) begin
                    offer(hv[$urandom_range(0, i - 1)]);
                    chk("rnd_dup", int'(dup_err), 1);
                    chk("rnd_dup_range", int'(range_err), 0);
                    chk("rnd_dup_count", int'(count), i);
                end
                1: begin
                    offer(6'(52 + $urandom_range(0, 11)));
                    chk("rnd_range", int'(range_err), 1);
                    chk("rnd_range_dup", int'(dup_err), 0);
                    chk("rnd_range_count", int'(count), i);
                end
                2: begin
                    tick();
                    chk("rnd_idle_err", int'(dup_err | range_err), 0);
                end
                default: ;
            endcase
            offer(hv[i]);
            chk("rnd_accept_err", int'(dup_err | range_err), 0);
            if (i < 6) chk("rnd_count", int'(count), i + 1);
        end
        ref_eval(hv, ecls, ehi);
        check_result(ecls, ehi);
    endtask

    vec_t tbl[10];

    initial begin
        int ecls, ehi;
        tbl[0] = '{c: mk(8, 9, 10, 11, 12, 13, 26),  cls: 4'd8, hi: 4'd12};
        tbl[1] = '{c: mk(12, 13, 1, 2, 29, 20, 44),  cls: 4'd4, hi: 4'd12};
        tbl[2] = '{c: mk(0, 13, 26, 1, 14, 5, 6),    cls: 4'd6, hi: 4'd6};
        tbl[3] = '{c: mk(3, 16, 29, 42, 0, 7, 20),   cls: 4'd7, hi: 4'd7};
        tbl[4] = '{c: mk(13, 15, 17, 19, 23, 0, 51), cls: 4'd5, hi: 4'd12};
        tbl[5] = '{c: mk(0, 13, 1, 14, 5, 20, 35),   cls: 4'd2, hi: 4'd9};
        tbl[6] = '{c: mk(4, 17, 30, 0, 8, 22, 50),   cls: 4'd3, hi: 4'd11};
        tbl[7] = '{c: mk(2, 15, 4, 19, 34, 49, 12),  cls: 4'd1, hi: 4'd12};
        tbl[8] = '{c: mk(0, 14, 28, 42, 4, 17, 30),  cls: 4'd4, hi: 4'd4};
        tbl[9] = '{c: mk(0, 1, 2, 3, 5, 17, 40),     cls: 4'd5, hi: 4'd5};

        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", int'(card_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_class", int'(hand_class), 0);
        chk("rst_high", int'(high_rank), 0);
        rst = 1'b0;
        offer(6'd7);
        chk("idle_ready", int'(card_ready), 0);
        chk("idle_count", int'(count), 0);
        chk("idle_err", int'(dup_err | range_err), 0);

        for (int k = 0; k < 10; k++) run_hand(tbl[k].c, int'(tbl[k].cls), int'(tbl[k].hi));

        // card_valid in DONE is ignored; start wins over card_valid.
        offer(6'd3);
        chk("done_ignore_count", int'(count), 7);
        chk("done_ignore_done", int'(done), 1);
        chk("done_ignore_err", int'(dup_err | range_err), 0);
        start = 1'b1; card_valid = 1'b1; card = 6'd3;
        tick();
        start = 1'b0; card_valid = 1'b0;
        chk("restart_count", int'(count), 0);
        chk("restart_done", int'(done), 0);
        chk("restart_busy", int'(busy), 1);
        chk("restart_err", int'(dup_err | range_err), 0);
        offer(6'd3);
        chk("restart_card3_dup", int'(dup_err), 0);
        chk("restart_card3_count", int'(count), 1);

        // Duplicate then out-of-range, then finish the hand.
        do_start();
        offer(6'd5);
        chk("err_first_count", int'(count), 1);
        offer(6'd5);
        chk("dup_pulse", int'(dup_err), 1);
        chk("dup_no_range", int'(range_err), 0);
        chk("dup_count", int'(count), 1);
        chk("dup_ready", int'(card_ready), 1);
        offer(6'd60);
        chk("range_pulse", int'(range_err), 1);
        chk("range_no_dup", int'(dup_err), 0);
        chk("range_count", int'(count), 1);
        chk("range_ready", int'(card_ready), 1);
        tick();
        chk("pulse_clears", int'(dup_err | range_err), 0);
        offer(6'd63);
        chk("range_63", int'(range_err), 1);
        offer(6'd18); offer(6'd31); offer(6'd44); offer(6'd0); offer(6'd1);
        chk("err_hand_count", int'(count), 6);
        offer(6'd2);
        ref_eval(mk(5, 18, 31, 44, 0, 1, 2), ecls, ehi);
        check_result(ecls, ehi);

        // Reset while holding a result, then mid-hand.
        #2 rst = 1'b1;
        #1;
        chk("rst_done_class", int'(hand_class), 0);
        chk("rst_done_high", int'(high_rank), 0);
        chk("rst_done_done", int'(done), 0);
        tick();
        rst = 1'b0;
        do_start();
        offer(6'd0); offer(6'd1); offer(6'd2);
        chk("mid_count", int'(count), 3);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_ready", int'(card_ready), 0);
        chk("mid_rst_busy", int'(busy), 0);
        tick();
        rst = 1'b0;
        offer(6'd9);
        offer(6'd10);
        chk("post_rst_ignored", int'(count), 0);
        chk("post_rst_err", int'(dup_err | range_err), 0);
        run_hand(tbl[2].c, int'(tbl[2].cls), int'(tbl[2].hi));

        for (int n = 0; n < 40; n++) random_hand();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
